// File: rtl/down_timer_pkg.sv
// Shared types and default sizing for the loadable down-counting timer.
package down_timer_pkg;

    localparam int unsigned DT_WIDTH        = 4;
    localparam int unsigned DT_PRESCALE_DIV = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } dt_state_e;

endpackage

// File: rtl/down_timer_tick_prescaler.sv
// Divides clk into a one-cycle decrement tick every DIV enabled cycles.
// Only instantiated when DOWN_TIMER_PRESCALE_EN is defined.
module tick_prescaler
    import down_timer_pkg::*;
#(
    parameter int unsigned DIV = DT_PRESCALE_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick_c
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_phase;
    logic          w_last;

    assign w_last = (r_phase == CW'(DIV - 1));
    assign tick_c = enable && w_last;

    // Phase only advances while enabled, so a paused timer keeps its phase.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase <= '0;
        end else if (clear) begin
            r_phase <= '0;
        end else if (enable) begin
            r_phase <= w_last ? '0 : r_phase + CW'(1);
        end
    end

endmodule

// File: rtl/down_timer.sv
// Loadable down timer with one-shot/periodic modes and start/stop/pause control.
// Optional DOWN_TIMER_PRESCALE_EN slows decrements to one per PRESCALE_DIV clocks.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned WIDTH = DT_WIDTH
`ifdef DOWN_TIMER_PRESCALE_EN
    ,
    parameter int unsigned PRESCALE_DIV = DT_PRESCALE_DIV
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    dt_state_e        r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_reload, w_reload_nxt;
    logic             r_done, w_done_nxt;
    logic             r_busy;
    logic             w_tick;
    logic             w_pre_clear;
    logic             w_pre_en;

    // Prescaler runs only on cycles that would otherwise decrement.
    assign w_pre_en = (r_state == ST_RUN) && !load && !stop;

`ifdef DOWN_TIMER_PRESCALE_EN
    tick_prescaler #(
        .DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (w_pre_clear),
        .enable(w_pre_en),
        .tick_c(w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_count  <= '0;
            r_reload <= '0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_count  <= w_count_nxt;
            r_reload <= w_reload_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= (w_state_nxt == ST_RUN);
        end
    end

    // Control priority is load > stop > start.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_reload_nxt = r_reload;
        w_done_nxt   = 1'b0;
        w_pre_clear  = 1'b0;

        if (load) begin
            w_count_nxt  = load_value;
            w_reload_nxt = load_value;
            w_state_nxt  = ST_IDLE;
            w_pre_clear  = 1'b1;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start && (r_count != '0)) begin
                        w_state_nxt = ST_RUN;
                        w_pre_clear = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        w_state_nxt = ST_PAUSE;
                    end else if (w_tick) begin
                        if (r_count > WIDTH'(1)) begin
                            w_count_nxt = r_count - WIDTH'(1);
                        end else begin
                            w_done_nxt = 1'b1;
                            // A zero reload would stall at 0, so it behaves as one-shot.
                            if (periodic && (r_reload != '0)) begin
                                w_count_nxt = r_reload;
                            end else begin
                                w_count_nxt = '0;
                                w_state_nxt = ST_IDLE;
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        w_state_nxt = ST_IDLE;
                    end else if (start) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus random control traffic
// compared against a behavioural timer model.
module tb_down_timer;
    import down_timer_pkg::*;

    localparam int unsigned W = 4;
`ifdef DOWN_TIMER_PRESCALE_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         stop;
    logic         periodic;
    logic [W-1:0] count;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: mode flags, value, reload, tick phase.
    bit m_run, m_pause, m_done;
    int m_cnt, m_rel, m_phase;

    down_timer #(
        .WIDTH(W)
`ifdef DOWN_TIMER_PRESCALE_EN
        , .PRESCALE_DIV(DIV)
`endif
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_value(load_value),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .count     (count),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_pause = 0; m_done = 0;
        m_cnt = 0; m_rel = 0; m_phase = 0;
    endtask

    task automatic model_edge(input bit l, input int lv, input bit s, input bit p, input bit per);
        bit tick;
        m_done = 0;
        if (l) begin
            m_cnt = lv; m_rel = lv; m_run = 0; m_pause = 0; m_phase = 0;
        end else if (m_run) begin
            if (p) begin
                m_run = 0; m_pause = 1;
            end else begin
                tick = (m_phase == DIV - 1);
                m_phase = tick ? 0 : m_phase + 1;
                if (tick) begin
                    if (m_cnt > 1) m_cnt = m_cnt - 1;
                    else begin
                        m_done = 1;
                        if (per && m_rel != 0) m_cnt = m_rel;
                        else begin m_cnt = 0; m_run = 0; end
                    end
                end
            end
        end else if (m_pause) begin
            if (p) m_pause = 0;
            else if (s) begin m_pause = 0; m_run = 1; end
        end else if (s && m_cnt != 0) begin
            m_run = 1; m_phase = 0;
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, ".count"}, int'(count), m_cnt);
        chk({tag, ".busy"},  int'(busy),  int'(m_run));
        chk({tag, ".done"},  int'(done),  int'(m_done));
    endtask

    // Apply one cycle of inputs, advance model at the edge, compare 1 time unit later.
    task automatic cycle(input bit l, input int lv, input bit s, input bit p, input bit per,
                         input string tag);
        load = l; load_value = W'(lv); start = s; stop = p; periodic = per;
        @(posedge clk);
        model_edge(l, lv, s, p, per);
        #1;
        compare(tag);
    endtask

    int cyc;
    int exp_seq[5] = '{4, 3, 2, 1, 0};
    int per_seq[6] = '{2, 1, 3, 2, 1, 3};

    initial begin
        reset = 1'b1; load = 0; load_value = '0; start = 0; stop = 0; periodic = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare("reset");
        reset = 1'b0;

        // One-shot from 5
        cycle(1, 5, 0, 0, 0, "os_load");
        chk("os_load_val", int'(count), 5);
        cycle(0, 0, 1, 0, 0, "os_start");
        chk("os_start_busy", int'(busy), 1);
`ifndef DOWN_TIMER_PRESCALE_EN
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0, 0, "os_run");
            chk("os_seq", int'(count), exp_seq[i]);
        end
        chk("os_done_at_zero", int'(done), 1);
        chk("os_busy_fell", int'(busy), 0);
        cycle(0, 0, 0, 0, 0, "os_hold");
        chk("os_done_single", int'(done), 0);
`else
        for (int i = 0; i < 5 * DIV; i++) cycle(0, 0, 0, 0, 0, "os_run");
        chk("os_final_zero", int'(count), 0);
`endif

        // Periodic from 3
        cycle(1, 3, 0, 0, 1, "per_load");
        cycle(0, 0, 1, 0, 1, "per_start");
`ifndef DOWN_TIMER_PRESCALE_EN
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 0, 1, "per_run");
            chk("per_seq", int'(count), per_seq[i]);
            chk("per_done", int'(done), (i % 3 == 2) ? 1 : 0);
        end
`endif
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, "per_run");
        chk("per_busy", int'(busy), 1);

        // Pause/resume from 15
        cycle(1, 15, 0, 0, 0, "pz_load");
        cycle(0, 0, 1, 0, 0, "pz_start");
        for (int i = 0; i < 4 * DIV; i++) cycle(0, 0, 0, 0, 0, "pz_run");
        cycle(0, 0, 0, 1, 0, "pz_stop");
        chk("pz_hold11", int'(count), 11);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0, "pz_paused");
        chk("pz_busy0", int'(busy), 0);
        cycle(0, 0, 1, 0, 0, "pz_resume");
        for (int i = 0; i < DIV; i++) cycle(0, 0, 0, 0, 0, "pz_run2");
        chk("pz_resumed10", int'(count), 10);

        // Priority cases
        cycle(1, 7, 1, 0, 0, "pri_load_start");
        chk("pri_load_idle", int'(busy), 0);
        cycle(1, 0, 0, 0, 0, "pri_load0");
        cycle(0, 0, 1, 0, 0, "pri_start_zero");
        chk("pri_zero_idle", int'(busy), 0);
        cycle(1, 6, 0, 0, 0, "pri_load6");
        cycle(0, 0, 1, 0, 0, "pri_start6");
        cycle(0, 0, 1, 1, 0, "pri_start_stop");
        chk("pri_stop_wins", int'(busy), 0);
        cycle(0, 0, 0, 1, 0, "pri_abandon");
        cycle(0, 0, 0, 0, 0, "pri_idle");

        // Asynchronous reset mid-run
        cycle(1, 9, 0, 0, 0, "rst_load");
        cycle(0, 0, 1, 0, 0, "rst_start");
        for (int i = 0; i < 3 * DIV; i++) cycle(0, 0, 0, 0, 0, "rst_run");
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare("rst_async");
        @(posedge clk);
        #1 reset = 1'b0;
        cycle(0, 0, 1, 0, 0, "rst_start_ignored");

`ifdef DOWN_TIMER_PRESCALE_EN
        // Expiry latency with prescaler: load 2 -> done 2*DIV edges after start edge
        cycle(1, 2, 0, 0, 0, "ps_load");
        cycle(0, 0, 1, 0, 0, "ps_start");
        cyc = 0;
        while (!done && cyc < 50) begin
            cycle(0, 0, 0, 0, 0, "ps_run");
            cyc++;
        end
        chk("ps_latency", cyc, 2 * DIV);
`endif

        // Random control traffic
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 3) != 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/down_timer.md
Name: down_timer

Overview:
Loadable down-counting timer. It counts a programmed value down to zero and flags expiry with a one-cycle pulse. Used wherever the design needs a countdown delay or periodic tick, as the complement to the free-running up counters. Supports one-shot and periodic (auto-reload) modes, with start/stop/pause control.

Parameters:
WIDTH, 4, bit width of count, load_value and reload register
PRESCALE_DIV, 4, clk cycles per decrement tick; used only when DOWN_TIMER_PRESCALE_EN is defined; legal range >= 2

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
load  input  1  when high, capture load_value into count and the reload register
load_value  input  WIDTH  value to count down from
start  input  1  begin counting from IDLE, or resume from PAUSE
stop  input  1  pause counting from RUN; abandon from PAUSE
periodic  input  1  1 = auto-reload on expiry, 0 = one-shot; sampled at the expiry tick
count  output  WIDTH  current counter value, registered
busy  output  1  high while state == RUN, registered
done  output  1  one-cycle expiry pulse, registered

Behaviour:
- Interface: reset is asynchronous and active-high; clock is clk.
- Reset values: count = 0, reload register = 0, state = IDLE, busy = 0, done = 0. Reset is asynchronous and takes effect mid-operation immediately, with no completion pulse.
- FSM states: IDLE, RUN, PAUSE. busy = (state == RUN).
- Control priority, highest first: load > stop > start.
- load (any state): count <= load_value, reload <= load_value, state -> IDLE, done <= 0. A start or stop in the same cycle is ignored.
- IDLE + start: if count != 0, go to RUN. If count == 0, start is ignored and stays IDLE; no done pulse.
- RUN + stop: go to PAUSE; count is held.
- RUN + start: ignored.
- RUN, start and stop together: stop wins, go to PAUSE.
- PAUSE + start: go to RUN and resume from the held count.
- PAUSE + stop: go to IDLE; count is held.
- RUN, each tick (every clk without the optional feature):
  - count > 1: count <= count - 1.
  - count == 1 and periodic = 0: count <= 0, done <= 1, state -> IDLE.
  - count == 1 and periodic = 1: count <= reload, done <= 1, stay in RUN.
  - count == 1, periodic = 1 and reload == 0: treated as one-shot.
- Count never wraps below 0, and no decrement occurs outside RUN.
- done is high for exactly one cycle per expiry and is deasserted on every other edge.
- Latency, one-shot: load L, then start sampled at edge E0. Decrements occur at edges E1..EL. At EL, count = 0 and done = 1; busy falls at the same edge.
- Latency, periodic: period = L cycles, and done pulses every L cycles. In periodic mode count shows L..1 and never 0.

Optional Feature:
DOWN_TIMER_PRESCALE_EN
- Defined: decrement ticks occur once every PRESCALE_DIV clk cycles.
  - The prescaler clears on load, on the IDLE->RUN transition and on reset.
  - It is frozen in PAUSE and resumes from its held phase.
  - Expiry latency becomes L*PRESCALE_DIV cycles from start.
- Undefined: tick is constant 1, PRESCALE_DIV is ignored, and no prescaler logic is generated.

Decomposition:
- Package down_timer_pkg:
  - state typedef and encodings (IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2)
  - default WIDTH and PRESCALE_DIV constants
- Sub-module tick_prescaler (inputs: clk, reset, clear, enable; output: tick pulse):
  - instantiated only under DOWN_TIMER_PRESCALE_EN
  - the FSM and counter stay in down_timer

Test Plan:
- One-shot: WIDTH = 4, load 5, periodic = 0, start -> count 5,4,3,2,1,0 on successive edges; done = 1 only on the 0 cycle; busy 1 -> 0 at the same edge; count holds 0 afterwards.
- Periodic: load 3, periodic = 1, start, run 10 cycles -> count 3,2,1,3,2,1,3,...; done pulses every 3rd edge; busy stays 1.
- Pause/resume: load 15, start, stop after 4 decrements -> count holds 11 and busy = 0 for 10 cycles; start -> 10,9,... with no done pulse during the pause.
- Priority: load 7 with start in the same cycle -> count = 7, IDLE, busy = 0. Start with count = 0 -> no state change, done = 0. start and stop together in RUN -> PAUSE.
- Reset mid-run: load 9, start, assert reset asynchronously after 3 decrements -> count = 0, busy = 0, done = 0 immediately. After release, start alone -> ignored.
- With DOWN_TIMER_PRESCALE_EN and PRESCALE_DIV = 4: load 2, start -> done asserted exactly 8 clk cycles after the start edge.
